// File: rtl/serial_alu.sv
// Bit-serial 32-bit ALU: receives {B, A, op, crc4} as 11-bit frames on sin and answers C/flags or an error code on sout.
// Optional build macro SERIAL_ALU_CRC_CHECK_EN enables the CRC-4 command check.
module serial_alu #(
    parameter int unsigned RSP_GAP = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic sin,
    output logic sout
);
    typedef enum logic [1:0] {ST_RX, ST_CALC, ST_GAP, ST_TX} state_t;
    typedef enum logic {RX_IDLE, RX_BITS} rx_t;

    state_t      state_q, state_d;
    rx_t         rx_q, rx_d;
    logic [3:0]  rx_cnt_q, rx_cnt_d;
    logic [8:0]  rx_sh_q, rx_sh_d;
    logic [3:0]  frm_cnt_q, frm_cnt_d;
    logic [63:0] ba_q, ba_d;
    logic [2:0]  op_q, op_d;
    logic        err_data_q, err_data_d;
    logic [3:0]  gap_cnt_q, gap_cnt_d;
    logic [2:0]  tx_frm_q, tx_frm_d;
    logic [3:0]  tx_bit_q, tx_bit_d;
    logic [31:0] rsp_data_q, rsp_data_d;
    logic [7:0]  rsp_ctl_q, rsp_ctl_d;
    logic [2:0]  rsp_last_q, rsp_last_d;
    logic        sout_q, sout_d;
`ifdef SERIAL_ALU_CRC_CHECK_EN
    logic [3:0]  crc4_q, crc4_d;
`endif

    function automatic logic [3:0] crc4_f(input logic [67:0] v);
        logic [3:0] c;
        c = '0;
        for (int i = 67; i >= 0; i--)
            c = {c[2:0], 1'b0} ^ ((c[3] ^ v[i]) ? 4'h3 : 4'h0);
        return c;
    endfunction

    function automatic logic [2:0] crc3_f(input logic [36:0] v);
        logic [2:0] c;
        c = '0;
        for (int i = 36; i >= 0; i--)
            c = {c[1:0], 1'b0} ^ ((c[2] ^ v[i]) ? 3'h3 : 3'h0);
        return c;
    endfunction

    // ALU, flags and response encoding, consumed in CALC
    logic [31:0] b_w, a_w, c_w;
    logic [32:0] sum_w, dif_w;
    logic        carry_w, ovf_w, op_bad_w, err_crc_w;
    logic [3:0]  flags_w;
    logic [2:0]  crc3_w, err_cls_w;
    logic [7:0]  err_pay_w;

    assign b_w = ba_q[63:32];
    assign a_w = ba_q[31:0];

`ifdef SERIAL_ALU_CRC_CHECK_EN
    assign err_crc_w = (crc4_f({b_w, a_w, 1'b1, op_q}) != crc4_q);
`else
    assign err_crc_w = 1'b0;
`endif

    always_comb begin
        sum_w    = {1'b0, b_w} + {1'b0, a_w};
        dif_w    = {1'b0, b_w} - {1'b0, a_w};
        c_w      = '0;
        carry_w  = 1'b0;
        ovf_w    = 1'b0;
        op_bad_w = 1'b0;
        case (op_q)
            3'b000: c_w = b_w & a_w;
            3'b001: c_w = b_w | a_w;
            3'b100: begin
                c_w     = sum_w[31:0];
                carry_w = sum_w[32];
                ovf_w   = (b_w[31] == a_w[31]) && (c_w[31] != b_w[31]);
            end
            3'b101: begin
                c_w     = dif_w[31:0];
                carry_w = dif_w[32];
                ovf_w   = (b_w[31] != a_w[31]) && (c_w[31] != b_w[31]);
            end
            default: op_bad_w = 1'b1;
        endcase
        flags_w = {carry_w, ovf_w, (c_w == 32'd0), c_w[31]};
        crc3_w  = crc3_f({c_w, 1'b0, flags_w});
        if (err_data_q)     err_cls_w = 3'b100;
        else if (err_crc_w) err_cls_w = 3'b010;
        else if (op_bad_w)  err_cls_w = 3'b001;
        else                err_cls_w = 3'b000;
        err_pay_w = {1'b1, err_cls_w, err_cls_w, ^{1'b1, err_cls_w, err_cls_w}};
    end

    // Transmit bit selection: the last frame of a response is always the CTL frame
    logic       tx_typ_w, tx_bitv_w;
    logic [7:0] tx_byte_w, tx_pay_w;

    always_comb begin
        tx_typ_w = (tx_frm_q == rsp_last_q);
        case (tx_frm_q[1:0])
            2'd0:    tx_byte_w = rsp_data_q[31:24];
            2'd1:    tx_byte_w = rsp_data_q[23:16];
            2'd2:    tx_byte_w = rsp_data_q[15:8];
            default: tx_byte_w = rsp_data_q[7:0];
        endcase
        tx_pay_w = tx_typ_w ? rsp_ctl_q : tx_byte_w;
        case (tx_bit_q)
            4'd0:    tx_bitv_w = 1'b0;
            4'd1:    tx_bitv_w = tx_typ_w;
            4'd10:   tx_bitv_w = 1'b1;
            default: tx_bitv_w = tx_pay_w[3'(4'd9 - tx_bit_q)];
        endcase
    end

    always_comb begin
        state_d    = state_q;
        rx_d       = rx_q;
        rx_cnt_d   = rx_cnt_q;
        rx_sh_d    = rx_sh_q;
        frm_cnt_d  = frm_cnt_q;
        ba_d       = ba_q;
        op_d       = op_q;
        err_data_d = err_data_q;
        gap_cnt_d  = gap_cnt_q;
        tx_frm_d   = tx_frm_q;
        tx_bit_d   = tx_bit_q;
        rsp_data_d = rsp_data_q;
        rsp_ctl_d  = rsp_ctl_q;
        rsp_last_d = rsp_last_q;
        sout_d     = 1'b1;
`ifdef SERIAL_ALU_CRC_CHECK_EN
        crc4_d     = crc4_q;
`endif
        case (state_q)
            ST_RX: begin
                if (rx_q == RX_IDLE) begin
                    if (!sin) begin
                        rx_d     = RX_BITS;
                        rx_cnt_d = '0;
                    end
                end else if (rx_cnt_q != 4'd9) begin
                    rx_sh_d  = {rx_sh_q[7:0], sin};
                    rx_cnt_d = rx_cnt_q + 4'd1;
                end else begin
                    // sin now carries the stop bit; rx_sh_q holds {type, payload}
                    rx_d = RX_IDLE;
                    if (!sin || (!rx_sh_q[8] && frm_cnt_q == 4'd8) ||
                        (rx_sh_q[8] && frm_cnt_q != 4'd8)) begin
                        err_data_d = 1'b1;
                        frm_cnt_d  = '0;
                        state_d    = ST_CALC;
                    end else if (!rx_sh_q[8]) begin
                        ba_d      = {ba_q[55:0], rx_sh_q[7:0]};
                        frm_cnt_d = frm_cnt_q + 4'd1;
                    end else begin
                        err_data_d = 1'b0;
                        op_d       = rx_sh_q[6:4];
`ifdef SERIAL_ALU_CRC_CHECK_EN
                        crc4_d     = rx_sh_q[3:0];
`endif
                        frm_cnt_d  = '0;
                        state_d    = ST_CALC;
                    end
                end
            end
            ST_CALC: begin
                rsp_data_d = c_w;
                if (err_cls_w != 3'b000) begin
                    rsp_ctl_d  = err_pay_w;
                    rsp_last_d = 3'd0;
                end else begin
                    rsp_ctl_d  = {1'b0, flags_w, crc3_w};
                    rsp_last_d = 3'd4;
                end
                gap_cnt_d = '0;
                state_d   = ST_GAP;
            end
            ST_GAP: begin
                // The first start bit is launched on the edge that enters TX
                if (gap_cnt_q == 4'(RSP_GAP - 1)) begin
                    sout_d   = 1'b0;
                    tx_frm_d = '0;
                    tx_bit_d = 4'd1;
                    state_d  = ST_TX;
                end else begin
                    gap_cnt_d = gap_cnt_q + 4'd1;
                end
            end
            default: begin
                sout_d = tx_bitv_w;
                if (tx_bit_q == 4'd10) begin
                    tx_bit_d = '0;
                    if (tx_frm_q == rsp_last_q) state_d = ST_RX;
                    else                        tx_frm_d = tx_frm_q + 3'd1;
                end else begin
                    tx_bit_d = tx_bit_q + 4'd1;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_RX;
            rx_q       <= RX_IDLE;
            rx_cnt_q   <= '0;
            rx_sh_q    <= '0;
            frm_cnt_q  <= '0;
            ba_q       <= '0;
            op_q       <= '0;
            err_data_q <= 1'b0;
            gap_cnt_q  <= '0;
            tx_frm_q   <= '0;
            tx_bit_q   <= '0;
            rsp_data_q <= '0;
            rsp_ctl_q  <= '0;
            rsp_last_q <= '0;
            sout_q     <= 1'b1;
`ifdef SERIAL_ALU_CRC_CHECK_EN
            crc4_q     <= '0;
`endif
        end else begin
            state_q    <= state_d;
            rx_q       <= rx_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_sh_q    <= rx_sh_d;
            frm_cnt_q  <= frm_cnt_d;
            ba_q       <= ba_d;
            op_q       <= op_d;
            err_data_q <= err_data_d;
            gap_cnt_q  <= gap_cnt_d;
            tx_frm_q   <= tx_frm_d;
            tx_bit_q   <= tx_bit_d;
            rsp_data_q <= rsp_data_d;
            rsp_ctl_q  <= rsp_ctl_d;
            rsp_last_q <= rsp_last_d;
            sout_q     <= sout_d;
`ifdef SERIAL_ALU_CRC_CHECK_EN
            crc4_q     <= crc4_d;
`endif
        end
    end

    assign sout = sout_q;
endmodule

// File: doc/serial_alu.md
SERIAL_ALU -- requirements
Module: serial_alu

Interface
REQ-001 SHALL have parameter RSP_GAP, default 1: number of sout idle-high cycles between sampling the command ctl stop bit and driving the response start bit (range 1..15).
REQ-002 SHALL have port clk  input  1  single clock; all logic on posedge clk.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port sin  input  1  serial command line; idle high; sampled on posedge clk.
REQ-005 SHALL have port sout  output  1  serial response line; idle high; registered, updated on posedge clk.

Function
REQ-006 Frame format, both directions, 11 bits, one bit per clk: start=0, type (0=DATA, 1=CTL), 8 payload bits MSB first, stop=1.
REQ-007 Receiver SHALL detect a start bit as sin==0 sampled in RX_IDLE, then capture type, 8 payload bits and stop bit on the next 10 posedges.
REQ-008 Command SHALL be 8 DATA frames (B[31:24], B[23:16], B[15:8], B[7:0], A[31:24], A[23:16], A[15:8], A[7:0]) followed by 1 CTL frame with payload {1'b0, op[2:0], crc4[3:0]}.
REQ-009 op encoding: 000=AND, 001=OR, 100=ADD (C=B+A), 101=SUB (C=B-A); any other value is unknown.
REQ-010 Flags, 4 bits {carry, overflow, zero, negative}: carry = unsigned carry-out (ADD) or borrow B<A (SUB), 0 for AND/OR; overflow = signed overflow (ADD/SUB), 0 for AND/OR; zero = (C==0); negative = C[31].
REQ-011 crc4 SHALL be checked as CRC-4, polynomial x^4+x+1, init 0, over the 68-bit vector {B, A, 1'b1, op}.
REQ-012 OK response: 4 DATA frames C[31:24]..C[7:0], then 1 CTL frame with payload {1'b0, flags[3:0], crc3[2:0]}; crc3 = CRC-3, polynomial x^3+x+1, init 0, over {C, 1'b0, flags}.
REQ-013 Error response: a single CTL frame with payload {1'b1, err[5:0], parity}; err = {ERR_DATA, ERR_CRC, ERR_OP, ERR_DATA, ERR_CRC, ERR_OP}; parity = XOR of {1'b1, err} (even parity).
REQ-014 Error priority DATA > CRC > OP; exactly one error class SHALL be set per response.
REQ-015 ERR_DATA SHALL be raised by: a CTL frame received before 8 DATA frames; a 9th DATA frame; or any frame with stop bit 0. Response is issued after that frame, and the command is discarded.
REQ-016 ERR_CRC SHALL be raised on crc4 mismatch; ERR_OP SHALL be raised on an unknown op with a valid CRC.
REQ-017 Top FSM states: RX, CALC, GAP, TX. Transitions: RX->CALC on command CTL stop bit or error; CALC->GAP after 1 cycle; GAP->TX after RSP_GAP-1 further cycles; TX->RX after the last response stop bit.
REQ-018 Start bit of the first response frame SHALL appear on sout exactly RSP_GAP+1 posedges after the posedge that samples the command CTL stop bit.
REQ-019 Response frames SHALL be back-to-back with no idle between them; sout SHALL be 1 outside frames.
REQ-020 sin SHALL be ignored in CALC, GAP and TX; receiver re-arms in RX on the first posedge after the TX stop bit.

Reset
REQ-021 While rst is 1 at a posedge: sout=1, FSM=RX, receiver=RX_IDLE, frame counter=0, A/B/op/crc registers=0.
REQ-022 Reset asserted mid-receive or mid-transmit SHALL abort the operation with no partial response; sout=1 from the next posedge.
REQ-023 The first posedge with rst==0 SHALL be able to sample a start bit.

Configuration
REQ-024 Macro SERIAL_ALU_CRC_CHECK_EN defined: CRC-4 check per REQ-011/016 is active.
REQ-025 Macro SERIAL_ALU_CRC_CHECK_EN undefined: CRC-4 checker is not built, ERR_CRC is never raised, and crc4 is ignored; all other behaviour is unchanged.

Verification
REQ-026 AND, A=0xFFFF0000, B=0x0F0F0F0F, valid crc4 -> C=0x0F0F0000, flags=0000, crc3 matches model.
REQ-027 ADD, A=0xFFFFFFFF, B=0x00000001 -> C=0x00000000, flags=1010 (carry, zero); start bit at RSP_GAP+1 cycles after stop bit.
REQ-028 SUB, A=0x00000001, B=0x80000000 -> C=0x7FFFFFFF, flags=0100 (overflow).
REQ-029 7 DATA frames then CTL -> single CTL response, payload 0xC9; op=010 with valid crc4 -> payload 0x93; corrupted crc4 -> payload 0xA5 (with macro), normal response (without macro).
REQ-030 rst pulsed during the 2nd response frame -> sout=1 from the next posedge, no further frames; a following valid OR command is answered correctly.
